// File: rtl/logic_reduce_pkg.sv
// Shared types and the reduction helper for the round-robin reduction arbiter.
package logic_reduce_pkg;

  localparam int RSP_ID_W = 8;   // widest requester id a response can carry
  localparam int MAX_W    = 32;  // widest operand reduce3 accepts

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic                and_r;
    logic                or_r;
    logic                xor_r;
  } rsp_t;

  // Only the low w bits of v take part; the id field is left at zero.
  function automatic rsp_t reduce3(input logic [MAX_W-1:0] v, input int w);
    rsp_t r;
    r       = '0;
    r.and_r = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        r.and_r = r.and_r & v[i];
        r.or_r  = r.or_r  | v[i];
        r.xor_r = r.xor_r ^ v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/logic_reduce_arbiter_rr_pick.sv
// Rotating-priority encoder: the first set request strictly above ptr wins, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     winner
);

  logic w_found;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    gnt     = '0;
    winner  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      automatic int idx = (int'(ptr) + k) % NUM_REQ;
      if (!w_found && req[idx]) begin
        gnt[idx] = 1'b1;
        winner   = IDW'(idx);
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_reduce_arbiter.sv
// Round-robin arbiter sharing one AND/OR (optionally XOR) reduction slot among NUM_REQ requesters.
// Define LOGIC_REDUCE_XOR_EN to add the registered rsp_xor output.
module logic_reduce_arbiter
  import logic_reduce_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 3,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] operand,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_and,
  output logic                     rsp_or
`ifdef LOGIC_REDUCE_XOR_EN
  ,
  output logic                     rsp_xor
`endif
);

  slot_state_e          r_state;
  logic [IDW-1:0]       r_ptr;
  rsp_t                 r_rsp;

  logic [NUM_REQ-1:0]   w_pick_gnt;
  logic [IDW-1:0]       w_winner;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_op;
  rsp_t                 w_next;
  logic                 w_unused;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .gnt    (w_pick_gnt),
    .winner (w_winner)
  );

  // The slot takes a new result when empty or when it is drained in the same cycle.
  assign w_accept = (|req) && ((r_state == EMPTY) || rsp_ready) && !rst;
  assign gnt      = w_accept ? w_pick_gnt : '0;
  assign w_op     = operand[int'(w_winner)*WIDTH +: WIDTH];

  always_comb begin
    w_next    = reduce3(MAX_W'(w_op), WIDTH);
    w_next.id = RSP_ID_W'(w_winner);
`ifndef LOGIC_REDUCE_XOR_EN
    w_next.xor_r = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      r_state <= EMPTY;
      r_ptr   <= IDW'(NUM_REQ - 1);
      r_rsp   <= '0;
    end else if (w_accept) begin
      r_state <= FULL;
      r_ptr   <= w_winner;
      r_rsp   <= w_next;
    end else if ((r_state == FULL) && rsp_ready) begin
      r_state <= EMPTY;
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_id    = r_rsp.id[IDW-1:0];
  assign rsp_and   = r_rsp.and_r;
  assign rsp_or    = r_rsp.or_r;
`ifdef LOGIC_REDUCE_XOR_EN
  assign rsp_xor   = r_rsp.xor_r;
`endif

  // Upper id bits are never used for small NUM_REQ; xor_r is constant without the XOR option.
  assign w_unused = ^{r_rsp.id, r_rsp.xor_r};

  // A granted requester must still be requesting at the capture edge.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_hold
    assert property (@(posedge clk) disable iff (rst) gnt[g] |-> req[g])
      else $error("req[%0d] dropped while granted", g);
  end

endmodule
